// File: rtl/draw_arbiter_pkg.sv
// Shared types and widths for the draw arbiter: FSM state encoding and
// the VGA pixel coordinate/colour widths.
package draw_arbiter_pkg;

    localparam int X_W     = 9;
    localparam int Y_W     = 8;
    localparam int COLOR_W = 12;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SCAN       = 3'd1,
        GRANT      = 3'd2,
        WAIT_DONE  = 3'd3,
        FRAME_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/draw_arbiter_priority_encoder_lsb.sv
// Lowest-set-bit priority encoder: maps the pending-engine mask to the index
// of the engine that paints next (index 0 is painted first).
module draw_arbiter_priority_encoder_lsb #(
    parameter int N_SRC = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_SRC-1:0] mask,
    output logic [IDX_W-1:0] idx
);

    // Scanning downward lets the lowest set bit win.
    always_comb begin
        idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/draw_arbiter.sv
// Sequences the per-object draw engines in painter's order and muxes the granted
// engine's pixel stream onto the VGA write port. DRAW_TIMEOUT_EN adds a per-engine watchdog.
//
// state      | meaning
// IDLE       | waiting for frame_start
// SCAN       | pick lowest pending engine, or finish the frame
// GRANT      | one-cycle enable_draw to the chosen engine
// WAIT_DONE  | stream the engine's pixels until its done pulse
// FRAME_DONE | one-cycle frame_done, then back to IDLE
module draw_arbiter
    import draw_arbiter_pkg::*;
#(
    parameter int N_SRC          = 4,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     frame_start,
    input  logic [N_SRC-1:0]         src_active,
    input  logic [X_W*N_SRC-1:0]     src_x,
    input  logic [Y_W*N_SRC-1:0]     src_y,
    input  logic [COLOR_W*N_SRC-1:0] src_color,
    input  logic [N_SRC-1:0]         src_we,
    input  logic [N_SRC-1:0]         src_done,
    output logic [N_SRC-1:0]         enable_draw,
    output logic [X_W-1:0]           vga_x,
    output logic [Y_W-1:0]           vga_y,
    output logic [COLOR_W-1:0]       vga_color,
    output logic                     vga_we,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     timeout_err
);

    if ((1 << IDX_W) < N_SRC) begin : g_idx_w_check
        $error("IDX_W is too narrow to index N_SRC engines");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t             state_q, state_d;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [IDX_W-1:0]   cur_q, cur_d;
    logic [IDX_W-1:0]   lsb_idx;

    logic [X_W-1:0]     vga_x_q, vga_x_d;
    logic [Y_W-1:0]     vga_y_q, vga_y_d;
    logic [COLOR_W-1:0] vga_color_q, vga_color_d;
    logic               vga_we_q, vga_we_d;

    logic [X_W-1:0]     sel_x;
    logic [Y_W-1:0]     sel_y;
    logic [COLOR_W-1:0] sel_color;
    logic               sel_we;
    logic               sel_done;
    logic [N_SRC-1:0]   cur_onehot;

`ifdef DRAW_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0]   to_cnt_q, to_cnt_d;
    logic               timeout_err_q, timeout_err_d;
`endif

    draw_arbiter_priority_encoder_lsb #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_lsb (
        .mask (pending_q),
        .idx  (lsb_idx)
    );

    // Select the granted engine's slice; an out-of-range index selects nothing.
    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_color  = '0;
        sel_we     = 1'b0;
        sel_done   = 1'b0;
        cur_onehot = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (cur_q == IDX_W'(i)) begin
                sel_x         = src_x[i*X_W +: X_W];
                sel_y         = src_y[i*Y_W +: Y_W];
                sel_color     = src_color[i*COLOR_W +: COLOR_W];
                sel_we        = src_we[i];
                sel_done      = src_done[i];
                cur_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cur_d     = cur_q;
`ifdef DRAW_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    pending_d = src_active;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (pending_q == '0) begin
                    state_d = FRAME_DONE;
                end else begin
                    cur_d   = lsb_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d = WAIT_DONE;
`ifdef DRAW_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            WAIT_DONE: begin
                // A done pulse on the same cycle as the watchdog expiring wins.
                if (sel_done) begin
                    pending_d = pending_q & ~cur_onehot;
                    state_d   = SCAN;
                end
`ifdef DRAW_TIMEOUT_EN
                else if (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    pending_d     = pending_q & ~cur_onehot;
                    timeout_err_d = 1'b1;
                    state_d       = SCAN;
                end else begin
                    to_cnt_d = to_cnt_q + CNT_W'(1);
                end
`endif
            end
            FRAME_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        vga_x_d     = sel_x;
        vga_y_d     = sel_y;
        vga_color_d = sel_color;
        vga_we_d    = sel_we & (state_q == WAIT_DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            cur_q       <= '0;
            vga_x_q     <= '0;
            vga_y_q     <= '0;
            vga_color_q <= '0;
            vga_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            cur_q       <= cur_d;
            vga_x_q     <= vga_x_d;
            vga_y_q     <= vga_y_d;
            vga_color_q <= vga_color_d;
            vga_we_q    <= vga_we_d;
        end
    end

`ifdef DRAW_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign enable_draw = (state_q == GRANT) ? cur_onehot : '0;
    assign frame_done  = (state_q == FRAME_DONE);
    assign busy        = (state_q != IDLE);
    assign vga_x       = vga_x_q;
    assign vga_y       = vga_y_q;
    assign vga_color   = vga_color_q;
    assign vga_we      = vga_we_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// Self-checking bench for draw_arbiter: frame table, directed corner sequences,
// and a randomized run against a schedule-level reference model.
module tb_draw_arbiter;

`ifdef DRAW_TIMEOUT_EN
    localparam int TB_TO = 16;
    localparam int TO_PARAM = 16;
`else
    localparam int TB_TO = 0;
    localparam int TO_PARAM = 8192;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        frame_start = 1'b0;
    logic [3:0]  src_active = '0;
    logic [35:0] src_x = '0;
    logic [31:0] src_y = '0;
    logic [47:0] src_color = '0;
    logic [3:0]  src_we = '0;
    logic [3:0]  src_done = '0;
    logic [3:0]  enable_draw;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [11:0] vga_color;
    logic        vga_we;
    logic        busy;
    logic        frame_done;
    logic        timeout_err;

    int checks = 0;
    int failures = 0;

    draw_arbiter #(
        .N_SRC          (4),
        .IDX_W          (2),
        .TIMEOUT_CYCLES (TO_PARAM)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .frame_start (frame_start),
        .src_active  (src_active),
        .src_x       (src_x),
        .src_y       (src_y),
        .src_color   (src_color),
        .src_we      (src_we),
        .src_done    (src_done),
        .enable_draw (enable_draw),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_color   (vga_color),
        .vga_we      (vga_we),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] active;
        logic [3:0] first_en;
        int         n_grants;
    } frame_vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        frame_start = 1'b0;
        src_active  = '0;
        src_x       = '0;
        src_y       = '0;
        src_color   = '0;
        src_we      = '0;
        src_done    = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    // Each active engine finishes on its first WAIT_DONE cycle, so a frame of
    // n engines ends 2+3n cycles after frame_start.
    task automatic run_frame_table();
        frame_vec_t tbl[6];
        tbl[0] = '{4'b0001, 4'b0001, 1};
        tbl[1] = '{4'b1000, 4'b1000, 1};
        tbl[2] = '{4'b0110, 4'b0010, 2};
        tbl[3] = '{4'b1111, 4'b0001, 4};
        tbl[4] = '{4'b1010, 4'b0010, 2};
        tbl[5] = '{4'b0000, 4'b0000, 0};
        for (int v = 0; v < 6; v++) begin
            logic [3:0] first_en = '0;
            logic [3:0] done_next = '0;
            int first_rel = -1;
            int fd_rel = -1;
            int grants = 0;
            src_active  = tbl[v].active;
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            for (int rel = 1; rel <= 40; rel++) begin
                src_done  = done_next;
                done_next = enable_draw;
                if (enable_draw != '0) begin
                    grants++;
                    if (first_rel < 0) begin
                        first_rel = rel;
                        first_en  = enable_draw;
                    end
                end
                if (frame_done) fd_rel = rel;
                tick();
                if (fd_rel >= 0) break;
            end
            src_done = '0;
            chk($sformatf("tbl%0d_first_en", v), first_en, tbl[v].first_en);
            chk($sformatf("tbl%0d_first_rel", v), first_rel, (tbl[v].n_grants > 0) ? 2 : -1);
            chk($sformatf("tbl%0d_grants", v), grants, tbl[v].n_grants);
            chk($sformatf("tbl%0d_fd_rel", v), fd_rel, 2 + 3 * tbl[v].n_grants);
        end
    endtask

    task automatic seq_painter_order();
        src_active  = 4'b0101;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("a_busy_t1", busy, 1);
        chk("a_en_t1", enable_draw, 4'b0000);
        tick();
        chk("a_en_t2", enable_draw, 4'b0001);
        tick();
        chk("a_en_wait", enable_draw, 4'b0000);
        frame_start = 1'b1;
        src_active  = 4'b1111;
        src_done    = 4'b1010;
        tick();
        frame_start = 1'b0;
        src_done    = 4'b0000;
        chk("a_ignored_en", enable_draw, 4'b0000);
        chk("a_ignored_busy", busy, 1);
        src_done = 4'b0001;
        tick();
        src_done = 4'b0000;
        chk("a_en_c1", enable_draw, 4'b0000);
        tick();
        chk("a_en_c2", enable_draw, 4'b0100);
        tick();
        src_done = 4'b0100;
        tick();
        src_done = 4'b0000;
        chk("a_fd_d1", frame_done, 0);
        tick();
        chk("a_fd_d2", frame_done, 1);
        chk("a_busy_d2", busy, 1);
        tick();
        chk("a_fd_d3", frame_done, 0);
        chk("a_busy_d3", busy, 0);
        for (int i = 0; i < 4; i++) begin
            chk("a_no_queued_frame", {enable_draw, busy}, 5'b0);
            tick();
        end
    endtask

    task automatic seq_pixel_mux();
        src_active  = 4'b0010;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        chk("b_grant", enable_draw, 4'b0010);
        src_we   = 4'b0010;
        src_done = 4'b0010;
        tick();
        src_we   = 4'b0000;
        src_done = 4'b0000;
        chk("b_we_after_grant", vga_we, 0);
        src_x[9 +: 9]      = 9'd10;
        src_y[8 +: 8]      = 8'd20;
        src_color[12 +: 12] = 12'hF00;
        src_x[27 +: 9]     = 9'd300;
        src_y[24 +: 8]     = 8'd200;
        src_color[36 +: 12] = 12'h0AB;
        src_we = 4'b1010;
        tick();
        chk("b_vga_x", vga_x, 10);
        chk("b_vga_y", vga_y, 20);
        chk("b_vga_color", vga_color, 12'hF00);
        chk("b_vga_we", vga_we, 1);
        chk("b_fd_early", frame_done, 0);
        src_we = 4'b1000;
        tick();
        chk("b_we_other_engine", vga_we, 0);
        chk("b_x_other_engine", vga_x, 10);
        chk("b_busy_grant_done_ignored", busy, 1);
        src_done = 4'b0010;
        src_we   = 4'b0000;
        tick();
        src_done = 4'b0000;
        tick();
        chk("b_fd", frame_done, 1);
        tick();
        chk("b_idle", busy, 0);
    endtask

    task automatic seq_empty_frame();
        src_active  = 4'b0000;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("c_fd_t1", frame_done, 0);
        chk("c_en_t1", enable_draw, 4'b0000);
        tick();
        chk("c_fd_t2", frame_done, 1);
        chk("c_en_t2", enable_draw, 4'b0000);
        tick();
        chk("c_fd_t3", frame_done, 0);
        chk("c_busy_t3", busy, 0);
    endtask

    task automatic seq_reset_mid_wait();
        src_active  = 4'b0001;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
        src_x[0 +: 9]      = 9'h1AB;
        src_color[0 +: 12] = 12'hABC;
        src_we             = 4'b0001;
        tick();
        chk("e_we_before_reset", vga_we, 1);
        chk("e_busy_before_reset", busy, 1);
        #2 resetn = 1'b0;
        #1;
        chk("e_rst_busy", busy, 0);
        chk("e_rst_en", enable_draw, 4'b0000);
        chk("e_rst_fd", frame_done, 0);
        chk("e_rst_vga", {vga_we, vga_x, vga_y, vga_color}, 30'b0);
        clear_inputs();
        tick();
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("e_after_release", {enable_draw, busy, frame_done}, 6'b0);
        end
    endtask

    task automatic run_random(input int ncyc);
        int q[$];
        int cur = 0;
        int grant_at = -1;
        int fd_at = -1;
        int start_c = 0;
        bit fa = 1'b0;
        bit exp_err = 1'b0;
        bit exp_busy;
        bit waiting;
        bit advance;
        bit pv_valid = 1'b0;
        bit pv_we = 1'b0;
        logic [8:0]  pv_x = '0;
        logic [7:0]  pv_y = '0;
        logic [11:0] pv_c = '0;
        for (int k = 0; k < ncyc; k++) begin
            exp_busy = fa && (k > start_c);
            chk("rnd_busy", busy, exp_busy);
            chk("rnd_en", enable_draw, (fa && k == grant_at) ? 4'(1 << cur) : 4'b0);
            chk("rnd_fd", frame_done, fa && k == fd_at);
            chk("rnd_we", vga_we, pv_we);
            chk("rnd_err", timeout_err, exp_err);
            if (pv_valid) begin
                chk("rnd_x", vga_x, pv_x);
                chk("rnd_y", vga_y, pv_y);
                chk("rnd_color", vga_color, pv_c);
            end

            frame_start = ($urandom_range(0, 5) == 0);
            src_active  = 4'($urandom);
            src_done    = 4'($urandom & $urandom);
            src_we      = 4'($urandom);
            src_x       = 36'({$urandom, $urandom});
            src_y       = $urandom;
            src_color   = 48'({$urandom, $urandom});

            waiting  = fa && grant_at >= 0 && k > grant_at;
            pv_valid = fa && grant_at >= 0 && k >= grant_at;
            pv_x     = src_x[cur*9 +: 9];
            pv_y     = src_y[cur*8 +: 8];
            pv_c     = src_color[cur*12 +: 12];
            pv_we    = waiting && src_we[cur];

            advance = 1'b0;
            if (!exp_busy && frame_start) begin
                q.delete();
                for (int i = 0; i < 4; i++) if (src_active[i]) q.push_back(i);
                fa      = 1'b1;
                start_c = k;
                fd_at   = -1;
                advance = 1'b1;
            end else if (waiting) begin
                if (src_done[cur]) begin
                    advance = 1'b1;
                end else if (TB_TO > 0 && (k - grant_at - 1) == TB_TO - 1) begin
                    exp_err = 1'b1;
                    advance = 1'b1;
                end
            end else if (fa && k == fd_at) begin
                fa    = 1'b0;
                fd_at = -1;
            end
            if (advance) begin
                if (q.size() == 0) begin
                    grant_at = -1;
                    fd_at    = k + 2;
                end else begin
                    cur      = q.pop_front();
                    grant_at = k + 2;
                end
            end
            tick();
        end
        clear_inputs();
    endtask

`ifdef DRAW_TIMEOUT_EN
    task automatic seq_timeout();
        bit bad = 1'b0;
        src_active  = 4'b0011;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        chk("f_grant0", enable_draw, 4'b0001);
        for (int i = 0; i < 16; i++) begin
            tick();
            if (enable_draw != 4'b0000 || timeout_err != 1'b0) bad = 1'b1;
        end
        chk("f_wait_16_cycles", bad, 0);
        tick();
        chk("f_err_set", timeout_err, 1);
        chk("f_en_scan", enable_draw, 4'b0000);
        tick();
        chk("f_grant1", enable_draw, 4'b0010);
        tick();
        src_done = 4'b0010;
        tick();
        src_done = 4'b0000;
        tick();
        chk("f_fd", frame_done, 1);
        chk("f_err_sticky", timeout_err, 1);
        tick();
        chk("f_err_sticky_idle", timeout_err, 1);
        chk("f_idle", busy, 0);
    endtask
`endif

    initial begin
        clear_inputs();
        resetn = 1'b0;
        #3;
        chk("reset_outputs", {enable_draw, vga_x, vga_y, vga_color, vga_we, busy, frame_done, timeout_err}, 37'b0);
        tick();
        resetn = 1'b1;
        tick();
        chk("reset_idle", {enable_draw, busy, frame_done, vga_we}, 7'b0);

        run_frame_table();
        seq_painter_order();
        seq_pixel_mux();
        seq_empty_frame();
        seq_reset_mid_wait();
        do_reset();
        run_random(4000);
`ifdef DRAW_TIMEOUT_EN
        do_reset();
        seq_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench time limit exceeded");
    end

endmodule

// File: doc/draw_arbiter.md
Name: draw_arbiter

Overview:
- Sits directly downstream of the per-object draw engines (background, hook, gold/stone, game-over).
- Sequences them one at a time per frame in painter's order (index 0 first, higher indices overdraw).
- Multiplexes the granted engine's pixel stream (X/Y/colour/write-enable) onto the single VGA adapter write port.
- Reports frame completion to the top-level game FSM.

Parameters:
- N_SRC, 4, number of draw engines arbitrated.
- IDX_W, 2, width of the granted-index register; must satisfy 2**IDX_W >= N_SRC.
- TIMEOUT_CYCLES, 8192, watchdog limit per engine; used only with DRAW_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- frame_start  in  1  pulse requesting a frame redraw.
- src_active  in  N_SRC  mask of engines to draw this frame; sampled with frame_start.
- src_x  in  9*N_SRC  packed X from each engine; engine i occupies [9i+8:9i].
- src_y  in  8*N_SRC  packed Y; engine i occupies [8i+7:8i].
- src_color  in  12*N_SRC  packed 12-bit colour; engine i occupies [12i+11:12i].
- src_we  in  N_SRC  per-engine pixel write-enable.
- src_done  in  N_SRC  per-engine one-cycle done pulse.
- enable_draw  out  N_SRC  one-hot, one-cycle start pulse to the granted engine.
- vga_x  out  9  pixel X to the VGA adapter.
- vga_y  out  8  pixel Y to the VGA adapter.
- vga_color  out  12  pixel colour to the VGA adapter.
- vga_we  out  1  pixel write strobe to the VGA adapter.
- busy  out  1  high from frame acceptance until frame_done.
- frame_done  out  1  one-cycle pulse when all active engines have finished.
- timeout_err  out  1  sticky error flag; exists only with DRAW_TIMEOUT_EN.

Behaviour:
- Reset: all outputs are 0. State is IDLE; pending mask and grant index are 0; the pixel pipeline registers are cleared.
- Reset mid-frame aborts immediately. No frame_done is issued, and no enable_draw is issued after release.
- States and transitions:
  - IDLE: if frame_start=1, latch pending<=src_active and go to SCAN; otherwise stay.
  - SCAN: if pending==0, go to FRAME_DONE. Otherwise set cur<=index of the lowest set bit of pending and go to GRANT.
  - GRANT: enable_draw[cur]=1 for exactly this cycle; go to WAIT_DONE.
  - WAIT_DONE: when src_done[cur]=1, clear pending[cur] and go to SCAN; otherwise stay.
  - FRAME_DONE: frame_done=1 for exactly this cycle; go to IDLE.
- busy=1 in every state except IDLE.
- enable_draw and frame_done are decoded from the state register (Moore).
- frame_start timing:
  - A frame_start at cycle t in IDLE gives the first enable_draw at t+2.
  - frame_start while busy is ignored; it is not queued.
- Completion latency: src_done of the last engine at cycle t gives frame_done at t+2.
- src_active==0 gives frame_done 2 cycles after frame_start, with no enable_draw.
- src_done handling:
  - src_done from a non-granted engine is ignored.
  - src_done is only honoured in WAIT_DONE; in GRANT it is ignored.
- Pixel path latency is 1 cycle. Every clock, registers load:
  - vga_x/vga_y/vga_color <= src_x/src_y/src_color slice [cur].
  - vga_we <= src_we[cur] & (state==WAIT_DONE).
- src_we from non-granted engines never reaches vga_we.
- Outside WAIT_DONE, vga_we=0 on the following cycle; vga_x/vga_y/vga_color may hold stale values.
- Coordinates and colour pass through unmodified; no clipping or arithmetic.

Optional Feature:
- Macro: DRAW_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to WAIT_DONE and increments each cycle there.
  - When it reaches TIMEOUT_CYCLES-1 without src_done[cur], the arbiter treats it as done: it clears pending[cur], sets timeout_err<=1 (sticky until reset), and goes to SCAN.
  - A simultaneous src_done and timeout counts as done, with no error.
- Without the macro: WAIT_DONE waits indefinitely, there is no counter, and timeout_err is tied to 0.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=0, SCAN=1, GRANT=2, WAIT_DONE=3, FRAME_DONE=4 (3-bit);
  - coordinate/colour widths (X_W=9, Y_W=8, COLOR_W=12).
- One sub-module is natural: priority_encoder_lsb, an N_SRC-bit mask to IDX_W index of the lowest set bit, used in SCAN.

Test Plan:
- Reset, then frame_start with src_active=4'b0101 -> enable_draw=0001 at t+2. Engine 0 pulses done at c -> enable_draw=0100 at c+2; engine 2 done at d -> frame_done at d+2; busy falls with it.
- Granted engine 1 streams (x=10,y=20,color=12'hF00,we=1) while engine 3 drives we=1 -> vga_* shows engine 1 values one cycle later; engine 3 never appears.
- src_active=0 -> frame_done exactly 2 cycles after frame_start, no enable_draw.
- frame_start pulsed during WAIT_DONE, plus src_done from a non-granted engine -> both ignored; sequence unchanged.
- resetn asserted low mid-WAIT_DONE -> all outputs 0 immediately; after release no further enable_draw until a new frame_start.
- DRAW_TIMEOUT_EN with TIMEOUT_CYCLES=16, granted engine never done -> advances after 16 WAIT_DONE cycles; timeout_err=1 and stays set.
